// File: rtl/sram_uart_dumper_pkg.sv
// Shared definitions for the SRAM-to-UART dumper.
// Contents: FSM state encoding, UART frame constants and the idle level of the
// active-low SRAM control strobes.
package sram_uart_dumper_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RD_ADDR = 4'd1,
    ST_RD_WAIT = 4'd2,
    ST_TX_LO   = 4'd3,
    ST_WAIT_LO = 4'd4,
    ST_TX_HI   = 4'd5,
    ST_WAIT_HI = 4'd6,
    ST_NEXT    = 4'd7,
    ST_DONE    = 4'd8
  } state_t;

  localparam logic     START_BIT      = 1'b0;
  localparam logic     STOP_BIT       = 1'b1;
  localparam int       DATA_BITS      = 8;
  // Bit index 0 is the start bit, 1..8 the data bits, 9 the stop bit.
  localparam logic [3:0] LAST_BIT_IDX = 4'd9;
  localparam logic     SRAM_CTRL_IDLE = 1'b1;

endpackage

// File: rtl/sram_uart_dumper_if.sv
// Control/status and SRAM control bundle of the dumper.
// master: host side (drives start/base_addr/word_count, observes the rest).
// slave : dumper side.
// Signals: start, base_addr, word_count, busy, done, txd, addr2sram,
//          cs, we, oe, ub, lb (active-low SRAM strobes), LED_out.
interface sram_uart_dumper_if #(parameter int ADDR_W = 19);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] word_count;
  logic              busy;
  logic              done;
  logic              txd;
  logic [ADDR_W-1:0] addr2sram;
  logic              cs;
  logic              we;
  logic              oe;
  logic              ub;
  logic              lb;
  logic [7:0]        LED_out;

  modport master (
    output start, base_addr, word_count,
    input  busy, done, txd, addr2sram, cs, we, oe, ub, lb, LED_out
  );

  modport slave (
    input  start, base_addr, word_count,
    output busy, done, txd, addr2sram, cs, we, oe, ub, lb, LED_out
  );
endinterface

// File: rtl/sram_uart_dumper_uart_tx.sv
// 8N1 UART transmitter.
// Ports: clk, rst (async, active-high), tx_start (accepted only when idle),
//        tx_data (byte to send), tx_busy (high from the cycle after tx_start
//        through the end of the stop bit), txd (serial out, idle high).
// The start bit begins the cycle after tx_start; each bit lasts CLK_DIV cycles.
module uart_tx
  import sram_uart_dumper_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       txd
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] baud_cnt_q;
  logic [3:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             busy_q;
  logic             txd_q;

  // Baud counter, bit sequencing and serial output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt_q <= {CNT_W{1'b0}};
      bit_idx_q  <= 4'd0;
      shift_q    <= 8'h00;
      busy_q     <= 1'b0;
      txd_q      <= STOP_BIT;
    end else if (!busy_q) begin
      if (tx_start) begin
        busy_q     <= 1'b1;
        txd_q      <= START_BIT;
        baud_cnt_q <= {CNT_W{1'b0}};
        bit_idx_q  <= 4'd0;
        shift_q    <= tx_data;
      end
    end else if (baud_cnt_q == CNT_W'(CLK_DIV - 1)) begin
      baud_cnt_q <= {CNT_W{1'b0}};
      if (bit_idx_q == LAST_BIT_IDX) begin
        // Stop bit already on the line; just go idle.
        busy_q <= 1'b0;
      end else begin
        bit_idx_q <= bit_idx_q + 4'd1;
        if (bit_idx_q < 4'(DATA_BITS)) begin
          txd_q   <= shift_q[0];
          shift_q <= {1'b0, shift_q[7:1]};
        end else begin
          txd_q <= STOP_BIT;
        end
      end
    end else begin
      baud_cnt_q <= baud_cnt_q + CNT_W'(1);
    end
  end

  assign tx_busy = busy_q;
  assign txd     = txd_q;

endmodule

// File: rtl/sram_uart_dumper.sv
// Reads word_count 16-bit words from async SRAM starting at base_addr and
// sends each one over UART (8N1), low byte first.
// Ports: clk, rst (async, active-high), data_sram (SRAM data, only read;
//        never driven), bus (slave side of sram_uart_dumper_if: start,
//        base_addr, word_count in; busy, done, txd, addr2sram, cs, we, oe,
//        ub, lb, LED_out out).
module sram_uart_dumper
  import sram_uart_dumper_pkg::*;
#(
  parameter int CLK_DIV   = 434,
  parameter int SRAM_WAIT = 2,
  parameter int ADDR_W    = 19
) (
  input  logic                clk,
  input  logic                rst,
  inout  wire  [15:0]         data_sram,
  sram_uart_dumper_if.slave   bus
);

  localparam int WAIT_W = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] remaining_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [15:0]       word_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] addr2sram_q;
  logic              cs_q;
  logic              oe_q;
  logic              ub_q;
  logic              lb_q;
  logic [7:0]        led_q;
  logic              tx_start_q;
  logic [7:0]        tx_data_q;
  logic              tx_busy_s;
  logic              txd_s;

  // The dumper only reads the SRAM.
  assign data_sram = 16'hzzzz;

  uart_tx #(.CLK_DIV(CLK_DIV)) u_uart_tx (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start_q),
    .tx_data  (tx_data_q),
    .tx_busy  (tx_busy_s),
    .txd      (txd_s)
  );

  // Dump sequencer: SRAM read timing, byte hand-off to the UART, address walk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= {ADDR_W{1'b0}};
      remaining_q <= {ADDR_W{1'b0}};
      wait_cnt_q  <= {WAIT_W{1'b0}};
      word_q      <= 16'h0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr2sram_q <= {ADDR_W{1'b0}};
      cs_q        <= SRAM_CTRL_IDLE;
      oe_q        <= SRAM_CTRL_IDLE;
      ub_q        <= SRAM_CTRL_IDLE;
      lb_q        <= SRAM_CTRL_IDLE;
      led_q       <= 8'h00;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
    end else begin
      done_q     <= 1'b0;
      tx_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            addr_q      <= bus.base_addr;
            remaining_q <= bus.word_count;
            busy_q      <= 1'b1;
            if (bus.word_count == {ADDR_W{1'b0}}) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RD_ADDR;
            end
          end
        end
        ST_RD_ADDR: begin
          addr2sram_q <= addr_q;
          cs_q        <= 1'b0;
          oe_q        <= 1'b0;
          ub_q        <= 1'b0;
          lb_q        <= 1'b0;
          wait_cnt_q  <= WAIT_W'(SRAM_WAIT - 1);
          state_q     <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (wait_cnt_q == {WAIT_W{1'b0}}) begin
            word_q     <= data_sram;
            cs_q       <= SRAM_CTRL_IDLE;
            oe_q       <= SRAM_CTRL_IDLE;
            ub_q       <= SRAM_CTRL_IDLE;
            lb_q       <= SRAM_CTRL_IDLE;
            // Start strobe is registered, so it is raised here to be
            // high during TX_LO itself.
            tx_start_q <= 1'b1;
            tx_data_q  <= data_sram[7:0];
            state_q    <= ST_TX_LO;
          end else begin
            wait_cnt_q <= wait_cnt_q - WAIT_W'(1);
          end
        end
        ST_TX_LO: begin
          led_q   <= word_q[7:0];
          state_q <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (!tx_busy_s) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= word_q[15:8];
            state_q    <= ST_TX_HI;
          end
        end
        ST_TX_HI: begin
          led_q   <= word_q[15:8];
          state_q <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (!tx_busy_s) begin
            state_q <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          addr_q      <= addr_q + ADDR_W'(1);
          remaining_q <= remaining_q - ADDR_W'(1);
          if (remaining_q == ADDR_W'(1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_RD_ADDR;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.txd       = txd_s;
  assign bus.addr2sram = addr2sram_q;
  assign bus.cs        = cs_q;
  assign bus.we        = SRAM_CTRL_IDLE;
  assign bus.oe        = oe_q;
  assign bus.ub        = ub_q;
  assign bus.lb        = lb_q;
  assign bus.LED_out   = led_q;

endmodule

// File: tb/tb_sram_uart_dumper.sv
// Scoreboard bench for sram_uart_dumper with CLK_DIV=4, SRAM_WAIT=2 and a
// behavioural SRAM that returns data one cycle after the address.
module tb_sram_uart_dumper;

  localparam int CLK_DIV   = 4;
  localparam int SRAM_WAIT = 2;
  localparam int ADDR_W    = 19;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  wire  [15:0] data_sram;
  logic [15:0] sram_rd_q = 16'h0000;

  sram_uart_dumper_if #(.ADDR_W(ADDR_W)) bus ();

  sram_uart_dumper #(
    .CLK_DIV   (CLK_DIV),
    .SRAM_WAIT (SRAM_WAIT),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_sram (data_sram),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]        exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];

  int txd_low_cnt  = 0;
  int ctrl_low_cnt = 0;
  int we_low_cnt   = 0;
  int busy_cnt     = 0;
  int done_cnt     = 0;
  int abort_req    = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] sram_lookup(input logic [ADDR_W-1:0] a);
    case (a)
      19'h00010: sram_lookup = 16'hA55A;
      19'h7FFFF: sram_lookup = 16'h1122;
      19'h00000: sram_lookup = 16'h3344;
      19'h00001: sram_lookup = 16'h5566;
      19'h00020: sram_lookup = 16'hBEEF;
      default:   sram_lookup = 16'hDEAD;
    endcase
  endfunction

  // SRAM model: registered read, drives the bus only while selected.
  always @(posedge clk) sram_rd_q <= sram_lookup(bus.addr2sram);
  assign data_sram = (!bus.cs && !bus.oe) ? sram_rd_q : 16'hzzzz;

  // Activity counters and SRAM address scoreboard.
  initial begin : activity_mon
    logic cs_prev;
    cs_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!bus.txd) txd_low_cnt++;
        if (!bus.cs || !bus.oe || !bus.ub || !bus.lb) ctrl_low_cnt++;
        if (!bus.we) we_low_cnt++;
        if (bus.busy) busy_cnt++;
        if (bus.done) done_cnt++;
        if (cs_prev && !bus.cs) begin
          check_eq("addr_avail", 32'(exp_addr_q.size() != 0), 32'd1);
          if (exp_addr_q.size() != 0) check_eq("addr2sram", 32'(bus.addr2sram), 32'(exp_addr_q.pop_front()));
        end
      end
      cs_prev = bus.cs;
    end
  end

  // UART receiver: samples each bit mid-period, compares bytes in order.
  initial begin : uart_mon
    logic [7:0] b;
    logic       prev;
    logic       stop_v;
    int         cyc;
    int         last_start;
    int         frame_no;
    int         seen_abort;
    prev = 1'b1; cyc = 0; last_start = 0; frame_no = 0; seen_abort = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst && prev && !bus.txd) begin
        if (frame_no % 2 == 1) check_eq("lohi_gap_ok", 32'((cyc - last_start) >= 40 && (cyc - last_start) <= 42), 32'd1);
        last_start = cyc;
        repeat (2) begin @(negedge clk); cyc++; end
        check_eq("start_bit", 32'(bus.txd), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) begin @(negedge clk); cyc++; end
          b[i] = bus.txd;
        end
        repeat (CLK_DIV) begin @(negedge clk); cyc++; end
        stop_v = bus.txd;
        if (abort_req != seen_abort) begin
          seen_abort = abort_req;
          frame_no   = 0;
        end else begin
          check_eq("stop_bit", 32'(stop_v), 32'd1);
          check_eq("byte_avail", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check_eq("byte", 32'(b), 32'(exp_q.pop_front()));
          frame_no++;
        end
      end
      prev = bus.txd;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_start(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] cnt);
    bus.base_addr  = base;
    bus.word_count = cnt;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
  endtask

  task automatic push_word(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    exp_addr_q.push_back(a);
    exp_q.push_back(d[7:0]);
    exp_q.push_back(d[15:8]);
  endtask

  task automatic wait_done(input int limit, input string tag);
    logic found;
    found = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (bus.done) begin
        found = 1'b1;
        break;
      end
    end
    check_eq(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_txd_low(input int limit);
    logic found;
    found = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (!bus.txd) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("txd_fall_seen", 32'(found), 32'd1);
  endtask

  initial begin : watchdog
    #(400000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int d0, c0, t0, k;
    bus.start = 1'b0; bus.base_addr = '0; bus.word_count = '0;

    // Reset state
    tick(3);
    check_eq("rst_txd",  32'(bus.txd),  32'd1);
    check_eq("rst_cs",   32'(bus.cs),   32'd1);
    check_eq("rst_we",   32'(bus.we),   32'd1);
    check_eq("rst_oe",   32'(bus.oe),   32'd1);
    check_eq("rst_ublb", 32'({bus.ub, bus.lb}), 32'd3);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_addr", 32'(bus.addr2sram), 32'd0);
    check_eq("rst_led",  32'(bus.LED_out), 32'd0);
    rst = 1'b0;

    // Idle for 200 cycles
    tick(200);
    check_eq("idle_txd_low",  32'(txd_low_cnt),  32'd0);
    check_eq("idle_ctrl_low", 32'(ctrl_low_cnt), 32'd0);
    check_eq("idle_busy",     32'(busy_cnt),     32'd0);

    // Single word
    d0 = done_cnt;
    push_word(19'h00010, 16'hA55A);
    drive_start(19'h00010, 19'd1);
    check_eq("busy_after_start", 32'(bus.busy), 32'd1);
    wait_done(400, "single_done");
    tick(20);
    check_eq("single_led",    32'(bus.LED_out), 32'hA5);
    check_eq("single_dcnt",   32'(done_cnt - d0), 32'd1);
    check_eq("single_bytes",  32'(exp_q.size()), 32'd0);
    check_eq("single_busy",   32'(bus.busy), 32'd0);

    // Multi-word with address wrap
    d0 = done_cnt;
    push_word(19'h7FFFF, 16'h1122);
    push_word(19'h00000, 16'h3344);
    push_word(19'h00001, 16'h5566);
    drive_start(19'h7FFFF, 19'd3);
    wait_done(1200, "wrap_done");
    tick(20);
    check_eq("wrap_bytes", 32'(exp_q.size()), 32'd0);
    check_eq("wrap_addrs", 32'(exp_addr_q.size()), 32'd0);
    check_eq("wrap_led",   32'(bus.LED_out), 32'h55);
    check_eq("wrap_dcnt",  32'(done_cnt - d0), 32'd1);

    // Zero count
    d0 = done_cnt; c0 = ctrl_low_cnt; t0 = txd_low_cnt;
    drive_start(19'h00010, 19'd0);
    k = 0;
    while (!bus.done && k < 4) begin
      k++;
      @(negedge clk);
    end
    check_eq("zero_latency_ok", 32'(bus.done && k <= 2), 32'd1);
    tick(50);
    check_eq("zero_ctrl", 32'(ctrl_low_cnt - c0), 32'd0);
    check_eq("zero_txd",  32'(txd_low_cnt - t0),  32'd0);
    check_eq("zero_dcnt", 32'(done_cnt - d0),     32'd1);

    // Start while busy is ignored
    d0 = done_cnt;
    push_word(19'h00010, 16'hA55A);
    drive_start(19'h00010, 19'd1);
    wait_txd_low(50);
    drive_start(19'h00020, 19'd1);
    wait_done(400, "busy_done");
    tick(150);
    check_eq("busy_bytes", 32'(exp_q.size()), 32'd0);
    check_eq("busy_dcnt",  32'(done_cnt - d0), 32'd1);

    // Reset in the middle of data bit 3 of the first byte
    push_word(19'h00010, 16'hA55A);
    drive_start(19'h00010, 19'd1);
    wait_txd_low(50);
    tick(17);
    abort_req++;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_txd",  32'(bus.txd),  32'd1);
    check_eq("mid_rst_csoe", 32'({bus.cs, bus.oe}), 32'd3);
    check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
    exp_q.delete();
    exp_addr_q.delete();
    tick(30);
    rst = 1'b0;
    tick(2);
    d0 = done_cnt;
    push_word(19'h00010, 16'hA55A);
    drive_start(19'h00010, 19'd1);
    wait_done(400, "post_rst_done");
    tick(20);
    check_eq("post_rst_bytes", 32'(exp_q.size()), 32'd0);
    check_eq("post_rst_led",   32'(bus.LED_out), 32'hA5);
    check_eq("post_rst_dcnt",  32'(done_cnt - d0), 32'd1);

    check_eq("we_never_low", 32'(we_low_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_uart_dumper.md
Name: sram_uart_dumper

Overview:
- Reads a block of 16-bit words from the external async SRAM and transmits them over UART TX as 8N1 bytes, low byte first.
- It is the readback counterpart of the UART-to-SRAM loader and shares the same SRAM pins and LED conventions.
- Board top-level muxes the SRAM bus between loader and dumper using their enable/busy outputs.

Parameters:
- CLK_DIV, 434, clock cycles per UART bit (50 MHz / 115200); minimum 2
- SRAM_WAIT, 2, clock cycles oe held low before data is sampled; minimum 1
- ADDR_W, 19, SRAM word-address width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first word address, latched on start
- word_count  in  ADDR_W  number of words to dump, latched on start
- busy  out  1  high from the cycle after accepted start until DONE exits
- done  out  1  one-cycle pulse when the dump completes
- txd  out  1  UART serial output, idle high
- addr2sram  out  ADDR_W  SRAM address
- data_sram  inout  16  SRAM data bus; this block never drives it (always Z)
- cs  out  1  SRAM chip select, active-low
- we  out  1  SRAM write enable, active-low; constant 1
- oe  out  1  SRAM output enable, active-low
- ub  out  1  upper byte enable, active-low
- lb  out  1  lower byte enable, active-low
- LED_out  out  8  last byte handed to the transmitter

Behaviour:
- Reset values: busy=0, done=0, txd=1, addr2sram=0, cs=1, we=1, oe=1, ub=1, lb=1, LED_out=0, state=IDLE.
- Reset mid-operation aborts immediately. Any partial UART frame is truncated and txd returns to 1.
- FSM states: IDLE, RD_ADDR, RD_WAIT, TX_LO, WAIT_LO, TX_HI, WAIT_HI, NEXT, DONE.
- IDLE, start=1: latch addr=base_addr and remaining=word_count.
  - If word_count=0, go to DONE (no SRAM access, no frame).
  - Otherwise go to RD_ADDR.
  - start outside IDLE is ignored.
- RD_ADDR: drive addr2sram=addr, cs=0, oe=0, ub=0, lb=0. Load the wait counter. Go to RD_WAIT.
- RD_WAIT: hold the bus for SRAM_WAIT cycles.
  - On the last cycle, latch data_sram into word_reg.
  - Release cs/oe/ub/lb to 1 on the following cycle.
  - Go to TX_LO.
- TX_LO: pulse tx_start with word_reg[7:0]; LED_out<=word_reg[7:0]. Go to WAIT_LO.
- WAIT_LO: wait until tx_busy falls. Go to TX_HI.
- TX_HI: same as TX_LO with word_reg[15:8]. WAIT_HI: wait until tx_busy falls.
- NEXT: addr<=addr+1, wrapping modulo 2^ADDR_W (0x7FFFF -> 0x00000), and remaining<=remaining-1.
  - If remaining was 1, go to DONE; otherwise go to RD_ADDR.
- DONE: done=1 for exactly one cycle, busy=0 after it. Return to IDLE.
- A start pulse arriving on the same cycle DONE exits is not accepted; start is taken only in IDLE.
- UART framing:
  - Each byte is sent as start bit 0, data bits 0..7 LSB first, then stop bit 1.
  - Each bit lasts CLK_DIV cycles, so a frame is 10*CLK_DIV cycles.
  - The start bit begins the cycle after tx_start.
  - tx_busy stays high from tx_start through the end of the stop bit.
  - Back-to-back frames have at most 2 idle cycles between stop and next start. Within a word, the gap is WAIT_LO→TX_HI only.
- Total cycles per word: 1 + SRAM_WAIT + 2 frames + FSM overhead (≤6).

Decomposition:
- Shared package holds:
  - FSM state encoding constants
  - UART frame constants: START_BIT=0, STOP_BIT=1, DATA_BITS=8
  - SRAM control idle level (all 1)
- One sub-module, uart_tx:
  - Ports: clk, rst, tx_start, tx_data[7:0], tx_busy, txd; parameter CLK_DIV.
  - Contains the baud counter, 4-bit bit index and shift register.
- The dumper top contains the FSM, address/count registers, SRAM timing and word latch.

Test Plan (CLK_DIV=4, SRAM_WAIT=2, behavioural SRAM model with 1-cycle access):
- Idle after reset: no start -> txd=1, cs=oe=we=ub=lb=1, busy=0 for 200 cycles.
- Single word: SRAM[0x00010]=0xA55A, start with base=0x10, count=1 ->
  - Two frames decode to 0x5A then 0xA5.
  - Each frame is 40 cycles, LSB first.
  - LED_out=0xA5 at the end; one done pulse; we never 0; data_sram never driven.
- Multi-word wrap: base=0x7FFFF, count=3, SRAM[0x7FFFF]=0x1122, [0x00000]=0x3344, [0x00001]=0x5566 ->
  - Bytes 22 11 44 33 66 55 in order.
  - addr2sram sequence 7FFFF, 00000, 00001.
- Zero count: start with count=0 -> done pulses within 2 cycles, no cs/oe assertion, txd stays 1.
- Start while busy: second start (base=0x20) during frame 1 of a count=1 dump -> ignored; only 2 bytes sent, one done pulse.
- Reset mid-frame: assert rst during data bit 3 of the first byte ->
  - txd=1 and cs=oe=1 in the same cycle; busy=0.
  - A subsequent start runs the full dump correctly.
